// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles an 8-bit byte stream into little-endian
// N_BYTES-wide words (lane 0 = first byte). A word closes when full or on
// in_last. Closed words wait in a small circular FIFO and are presented with
// a contiguous keep mask and a packet-end flag.
module byte_word_packer #(
    parameter int N_BYTES   = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*N_BYTES-1:0]   out_data,
    output logic [N_BYTES-1:0]     out_keep,
    output logic                   out_last,
    output logic [15:0]            word_count
);

    localparam int IW = $clog2(N_BYTES);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int DW = 8 * N_BYTES;

    // Assembly state
    logic [IW-1:0]      r_idx;
    logic [DW-1:0]      r_asm;
    logic [N_BYTES-1:0] r_keep;

    // FIFO state
    logic [DW-1:0]      r_mem_data [OUT_DEPTH];
    logic [N_BYTES-1:0] r_mem_keep [OUT_DEPTH];
    logic               r_mem_last [OUT_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [15:0]        r_word_count;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [N_BYTES-1:0] w_lane_hit;
    logic [DW-1:0]      w_asm_word;
    logic [N_BYTES-1:0] w_keep_word;

    // in_ready depends only on the registered occupancy, never on out_ready
    assign in_ready  = (r_count < CW'(OUT_DEPTH));
    assign out_valid = (r_count != '0);

    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && ((r_idx == IW'(N_BYTES - 1)) || in_last);
    assign w_pop    = out_valid && out_ready;

    // Word as it looks including the byte being accepted this cycle
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lane
        assign w_lane_hit[gi]          = w_accept && (r_idx == IW'(gi));
        assign w_asm_word[8*gi +: 8]   = w_lane_hit[gi] ? in_data : r_asm[8*gi +: 8];
        assign w_keep_word[gi]         = w_lane_hit[gi] | r_keep[gi];
    end

    // Head fields; an empty FIFO shows zeros so stale entries never leak out
    assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_keep   = out_valid ? r_mem_keep[r_rd_ptr] : '0;
    assign out_last   = out_valid ? r_mem_last[r_rd_ptr] : 1'b0;
    assign word_count = r_word_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lane assembly: collect bytes, clear as soon as the word is handed to the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_asm  <= '0;
            r_keep <= '0;
        end else if (w_push) begin
            r_idx  <= '0;
            r_asm  <= '0;
            r_keep <= '0;
        end else if (w_accept) begin
            r_idx  <= r_idx + 1'b1;
            r_asm  <= w_asm_word;
            r_keep <= w_keep_word;
        end
    end

    // FIFO storage; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_asm_word;
            r_mem_keep[r_wr_ptr] <= w_keep_word;
            r_mem_last[r_wr_ptr] <= in_last;
        end
    end

    // FIFO pointers, occupancy and completed-handshake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_word_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop) begin
                r_rd_ptr     <= ptr_inc(r_rd_ptr);
                r_word_count <= r_word_count + 16'd1;
            end
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and random checks for byte_word_packer (N_BYTES=4, OUT_DEPTH=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    byte_word_packer #(.N_BYTES(4), .OUT_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .word_count (word_count)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    initial begin : main
        int          b;
        int          acc;
        int          sent;
        logic [31:0] held;
        logic [31:0] got [$];
        word_t       exp_q [$];
        word_t       w;
        logic [31:0] m_asm;
        logic [3:0]  m_keep;
        int          m_idx;
        int          occ;
        logic        pop;
        logic        push;
        logic        prev_stall;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_keep", out_keep, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Full word, back-to-back bytes
        drive(1, 8'h11, 0); chk("fw_in_ready", in_ready, 1);
        drive(1, 8'h22, 0);
        drive(1, 8'h33, 0);
        drive(1, 8'h44, 0);
        chk("fw_no_bypass", out_valid, 0);
        drive(0, 8'h00, 0);
        chk("fw_valid", out_valid, 1);
        chk("fw_data", out_data, 32'h44332211);
        chk("fw_keep", out_keep, 4'hF);
        chk("fw_last", out_last, 0);
        chk("fw_count_before", word_count, 0);
        @(negedge clk);
        chk("fw_count_after", word_count, 1);
        chk("fw_empty", out_valid, 0);

        // Partial word then single-byte packet
        drive(1, 8'hAA, 0);
        drive(1, 8'hBB, 1);
        drive(0, 8'h00, 0);
        chk("pw_data", out_data, 32'h0000BBAA);
        chk("pw_keep", out_keep, 4'h3);
        chk("pw_last", out_last, 1);
        drive(1, 8'h5C, 1);
        drive(0, 8'h00, 0);
        chk("sb_data", out_data, 32'h0000005C);
        chk("sb_keep", out_keep, 4'h1);
        chk("sb_last", out_last, 1);
        @(negedge clk);
        chk("pw_count", word_count, 3);

        // Backpressure: 12 bytes offered with out_ready low
        out_ready = 1'b0;
        b = 1; acc = 0; held = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b <= 12) begin in_valid = 1'b1; in_data = 8'(b); in_last = 1'b0; end
            else in_valid = 1'b0;
            if (c == 10) held = out_data;
            if (c == 11) chk("bp_stable", out_data, held);
            if (in_valid && in_ready) begin b++; acc++; end
        end
        chk("bp_accepted", acc, 8);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, 32'h04030201);
        chk("bp_keep", out_keep, 4'hF);
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (b <= 12) begin in_valid = 1'b1; in_data = 8'(b); in_last = 1'b0; end
            else in_valid = 1'b0;
            if (in_valid && in_ready) b++;
            if (out_valid) got.push_back(out_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_words", got.size(), 3);
        chk("bp_word0", (got.size() > 0) ? got[0] : 32'hx, 32'h04030201);
        chk("bp_word1", (got.size() > 1) ? got[1] : 32'hx, 32'h08070605);
        chk("bp_word2", (got.size() > 2) ? got[2] : 32'hx, 32'h0C0B0A09);
        chk("bp_count", word_count, 6);

        // Reset in the middle of a word
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_out_keep", out_keep, 0);
        chk("mr_out_last", out_last, 0);
        chk("mr_word_count", word_count, 0);
        chk("mr_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 8'h10, 0);
        drive(1, 8'h20, 0);
        drive(1, 8'h30, 0);
        drive(1, 8'h40, 0);
        drive(0, 8'h00, 0);
        chk("mr_data", out_data, 32'h40302010);
        chk("mr_keep", out_keep, 4'hF);
        @(negedge clk);
        chk("mr_count", word_count, 1);

        // Counter wrap: 65534 single-byte packets take the count to 0xFFFF
        sent = 0;
        for (int c = 0; c < 70000 && sent < 65534; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(c); in_last = 1'b1;
            if (in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wr_sent", sent, 65534);
        chk("wr_ffff", word_count, 16'hFFFF);
        drive(1, 8'h5C, 1);
        drive(0, 8'h00, 0);
        chk("wr_data", out_data, 32'h0000005C);
        chk("wr_before", word_count, 16'hFFFF);
        @(negedge clk);
        chk("wr_wrap", word_count, 16'h0000);

        // Random stress against a reference scoreboard, then drain
        m_asm = '0; m_keep = '0; m_idx = 0; occ = 0; prev_stall = 1'b0;
        pd = '0; pk = '0; pl = 1'b0;
        for (int c = 0; c < 620; c++) begin
            @(negedge clk);
            chk("st_in_ready", in_ready, occ < 2);
            chk("st_out_valid", out_valid, occ > 0);
            if (prev_stall) begin
                chk("st_hold_data", out_data, pd);
                chk("st_hold_keep", out_keep, pk);
                chk("st_hold_last", out_last, pl);
            end
            out_ready = (c >= 600) ? 1'b1 : ($urandom_range(0, 2) != 0);
            pop = out_valid && out_ready;
            if (pop && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("st_data", out_data, w.d);
                chk("st_keep", out_keep, w.k);
                chk("st_last", out_last, w.l);
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pk = out_keep; pl = out_last;
            if (c >= 600) begin
                in_valid = (m_idx != 0);
                in_last  = 1'b1;
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_last  = ($urandom_range(0, 4) == 0);
            end
            in_data = 8'($urandom);
            push = 1'b0;
            if (in_valid && in_ready) begin
                m_asm[8*m_idx +: 8] = in_data;
                m_keep[m_idx] = 1'b1;
                if (m_idx == 3 || in_last) begin
                    w.d = m_asm; w.k = m_keep; w.l = in_last;
                    exp_q.push_back(w);
                    m_asm = '0; m_keep = '0; m_idx = 0;
                    push = 1'b1;
                end else begin
                    m_idx++;
                end
            end
            occ = occ + int'(push) - int'(pop);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("st_drained", exp_q.size(), 0);
        chk("st_final_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Packs the 8-bit byte stream from the datapath core into 32-bit words for the wide downstream interconnect. Bytes enter under a valid/ready handshake and are assembled little-endian (first byte in the least-significant lane). Each word completes when it is full or when `in_last` marks the end of a packet. Completed words are buffered in a small output FIFO and presented with a byte-keep mask and a packet-end flag.

## Interface
- `N_BYTES`, 4, bytes per output word; legal range 2..8.
- `OUT_DEPTH`, 2, output FIFO depth in words; legal range ≥1.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous assert and active-low. Release is synchronised externally.
- `in_valid` input 1: the input byte is valid.
- `in_ready` output 1: the block can accept a byte.
- `in_data` input 8: the input byte.
- `in_last` input 1: the accepted byte is the final byte of its packet.
- `out_valid` output 1: the word at the FIFO head is valid.
- `out_ready` input 1: the consumer accepts the word.
- `out_data` output 8*N_BYTES: the packed word.
- `out_keep` output N_BYTES: lane-valid mask.
- `out_last` output 1: the word ends a packet.
- `word_count` output 16: number of completed output handshakes, wrapping.

## Operation
- **Byte acceptance:** a byte is accepted when `in_valid && in_ready`.
- **`in_ready`:** equals FIFO occupancy < `OUT_DEPTH`. It is derived from registered state only, with no combinational path from `out_ready`.
- **Lane placement:**
  - A lane index `idx` (0..N_BYTES-1) selects the lane. The accepted byte is written to bits `[8*idx+7 : 8*idx]` of the assembly register, and the matching keep bit is set.
  - `idx` increments on each accepted byte.
- **Word completion:** a word completes on the accepted byte when `idx == N_BYTES-1` or `in_last == 1`. In that same cycle:
  - the assembled word, keep mask and `last = in_last` are pushed into the FIFO;
  - the assembly register and keep are cleared to 0;
  - `idx` returns to 0.
- **Partial words:** unused lanes carry data 0 and keep 0. Keep is always contiguous from bit 0.
- **Single-byte packet:** `in_last` with `idx == 0` produces one word with `keep = 1`.
- **FIFO:**
  - Circular buffer with read and write pointers that wrap at `OUT_DEPTH`, plus an occupancy counter.
  - Simultaneous push and pop leaves occupancy unchanged.
  - A push when full cannot occur because `in_ready` is low.
- **Output handshake:**
  - `out_data`, `out_keep` and `out_last` reflect the FIFO head.
  - While `out_valid && !out_ready`, all output fields stay stable.
  - A word leaves the FIFO on `out_valid && out_ready`, and `word_count` increments (0xFFFF wraps to 0x0000).
- **Bypass:** there is no bypass; an empty FIFO never presents the word being pushed in the same cycle.
- **Reset** (asynchronous, any time, including mid-word or with words buffered):
  - The FIFO is emptied and any partial word is discarded.
  - `idx`, the assembly register and `word_count` go to 0.
- **Reset values of outputs:**
  - `out_valid` 0
  - `out_data` 0
  - `out_keep` 0
  - `out_last` 0
  - `word_count` 0
  - `in_ready` 1, because the FIFO is empty

## Timing
- **Latency:** a completing byte accepted at edge t produces `out_valid == 1` with that word after edge t, i.e. one cycle.
- **Throughput:** one byte per cycle sustained when `out_ready` is held high, which gives one word every `N_BYTES` cycles.
- **Backpressure:**
  - With `out_ready` low, exactly `OUT_DEPTH` words are accepted. `in_ready` falls in the cycle after the push that fills the FIFO.
  - `in_ready` rises in the cycle after the first pop.
- **Order:** words leave in push order, with no reordering across pointer wrap-around.

## Test plan
- **Full word:** bytes 0x11, 0x22, 0x33, 0x44 (last=0) on back-to-back cycles with `out_ready` = 1.
  - Required: one cycle after the 4th byte, `out_data` = 0x44332211, `out_keep` = 0xF, `out_last` = 0, and `word_count` = 1 after the handshake.
- **Partial word:** bytes 0xAA, 0xBB with last on 0xBB.
  - Required: `out_data` = 0x0000BBAA, `out_keep` = 0x3, `out_last` = 1.
  - Then a single byte 0x5C with last: `out_data` = 0x0000005C, `out_keep` = 0x1, `out_last` = 1.
- **Backpressure:** `out_ready` = 0 with 12 bytes 0x01..0x0C offered.
  - Required: 8 bytes are accepted, then `in_ready` = 0.
  - `out_data` holds 0x04030201 stable.
  - Raising `out_ready` yields 0x04030201, 0x08070605, 0x0C0B0A09 in order.
- **Reset mid-operation:** accept 0x01, 0x02, assert `rst_n` = 0 for 1 cycle, release, then send 0x10, 0x20, 0x30, 0x40.
  - Required: outputs are at their reset values during reset.
  - The first word out is 0x40302010, with no stale bytes from before reset.
- **Counter wrap:** preload via 65,535 single-byte last packets (or force), then one more word.
  - Required: `word_count` goes 0xFFFF → 0x0000.
- **Random stress:** random `in_valid`/`out_ready` with `OUT_DEPTH` = 2 and random `in_last`.
  - Required: the scoreboard matches all words, keeps and lasts.
  - No output field changes while stalled.
